// File: rtl/clock_rtc_param.sv
// Parametrised hh:mm:ss counter with integrated prescaler, range-checked load and strobes.
// Define CLOCK_RTC_ALARM_EN to add the hour:minute alarm ports and logic.
module clock_rtc_param #(
    parameter int unsigned TICKS_PER_SEC = 100000000,
    parameter int unsigned SEC_MAX       = 60,
    parameter int unsigned MIN_MAX       = 60,
    parameter int unsigned HOUR_MAX      = 24,
    localparam int unsigned SW = $clog2(SEC_MAX),
    localparam int unsigned MW = $clog2(MIN_MAX),
    localparam int unsigned HW = $clog2(HOUR_MAX),
    localparam int unsigned PW = $clog2(TICKS_PER_SEC)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          load,
    input  logic [SW-1:0] load_sec,
    input  logic [MW-1:0] load_min,
    input  logic [HW-1:0] load_hour,
`ifdef CLOCK_RTC_ALARM_EN
    input  logic          alarm_wr,
    input  logic [HW-1:0] alarm_hour,
    input  logic [MW-1:0] alarm_min,
    input  logic          alarm_ack,
    output logic          alarm,
`endif
    output logic [SW-1:0] sec_cnt,
    output logic [MW-1:0] min_cnt,
    output logic [HW-1:0] hour_cnt,
    output logic          sec_tick,
    output logic          day_wrap,
    output logic          load_err
);

    localparam logic [PW-1:0] PreLast  = PW'(TICKS_PER_SEC - 1);
    localparam logic [SW-1:0] SecLast  = SW'(SEC_MAX - 1);
    localparam logic [MW-1:0] MinLast  = MW'(MIN_MAX - 1);
    localparam logic [HW-1:0] HourLast = HW'(HOUR_MAX - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [SW-1:0] sec_q, sec_d;
    logic [MW-1:0] min_q, min_d;
    logic [HW-1:0] hour_q, hour_d;
    logic          sec_tick_q, day_wrap_q, load_err_q;
    logic          adv, load_ok, wrap;

    always_comb begin
        adv     = en && (pre_q == PreLast);
        // Compare at 32 bits so a MAX equal to 2**W still rejects out-of-range codes.
        load_ok = load && (32'(load_sec) < SEC_MAX) && (32'(load_min) < MIN_MAX)
                       && (32'(load_hour) < HOUR_MAX);
        wrap    = adv && (sec_q == SecLast) && (min_q == MinLast) && (hour_q == HourLast);
        pre_d   = pre_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        if (en) begin
            pre_d = adv ? '0 : pre_q + 1'b1;
        end
        if (adv) begin
            if (sec_q != SecLast) begin
                sec_d = sec_q + 1'b1;
            end else begin
                sec_d = '0;
                if (min_q != MinLast) begin
                    min_d = min_q + 1'b1;
                end else begin
                    min_d  = '0;
                    hour_d = (hour_q != HourLast) ? hour_q + 1'b1 : '0;
                end
            end
        end
        if (load_ok) begin
            pre_d  = '0;
            sec_d  = load_sec;
            min_d  = load_min;
            hour_d = load_hour;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q      <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            sec_tick_q <= 1'b0;
            day_wrap_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            // A valid load swallows any coinciding advance, strobes included.
            sec_tick_q <= adv && !load_ok;
            day_wrap_q <= wrap && !load_ok;
            load_err_q <= load && !load_ok;
        end
    end

`ifdef CLOCK_RTC_ALARM_EN
    logic [HW-1:0] alarm_hour_q;
    logic [MW-1:0] alarm_min_q;
    logic          armed_q, alarm_q, match;

    assign match = adv && !load_ok && armed_q && (sec_d == '0)
                   && (min_d == alarm_min_q) && (hour_d == alarm_hour_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_hour_q <= '0;
            alarm_min_q  <= '0;
            armed_q      <= 1'b0;
            alarm_q      <= 1'b0;
        end else begin
            if (alarm_wr) begin
                alarm_hour_q <= alarm_hour;
                alarm_min_q  <= alarm_min;
                armed_q      <= 1'b1;
            end
            if (match) begin
                alarm_q <= 1'b1;
            end else if (alarm_ack) begin
                alarm_q <= 1'b0;
            end
        end
    end

    assign alarm = alarm_q;
`endif

    assign sec_cnt  = sec_q;
    assign min_cnt  = min_q;
    assign hour_cnt = hour_q;
    assign sec_tick = sec_tick_q;
    assign day_wrap = day_wrap_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_clock_rtc_param.sv
// Scoreboard bench for clock_rtc_param with TICKS_PER_SEC=4; expected strobe events are queued
// by the stimulus and matched by a negedge monitor against cycle number and field values.
module tb_clock_rtc_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [5:0] load_sec = '0;
    logic [5:0] load_min = '0;
    logic [4:0] load_hour = '0;
    logic [5:0] sec_cnt;
    logic [5:0] min_cnt;
    logic [4:0] hour_cnt;
    logic       sec_tick, day_wrap, load_err;
`ifdef CLOCK_RTC_ALARM_EN
    logic       alarm_wr = 1'b0;
    logic [4:0] alarm_hour = '0;
    logic [5:0] alarm_min = '0;
    logic       alarm_ack = 1'b0;
    logic       alarm;
`endif

    clock_rtc_param #(
        .TICKS_PER_SEC(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load      (load),
        .load_sec  (load_sec),
        .load_min  (load_min),
        .load_hour (load_hour),
`ifdef CLOCK_RTC_ALARM_EN
        .alarm_wr  (alarm_wr),
        .alarm_hour(alarm_hour),
        .alarm_min (alarm_min),
        .alarm_ack (alarm_ack),
        .alarm     (alarm),
`endif
        .sec_cnt   (sec_cnt),
        .min_cnt   (min_cnt),
        .hour_cnt  (hour_cnt),
        .sec_tick  (sec_tick),
        .day_wrap  (day_wrap),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int c;
        int s;
        int m;
        int h;
        int tick;
        int wrap;
        int err;
        int alm;
    } ev_t;

    ev_t q[$];
    ev_t mon_e;
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual %0d, required %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int c, input int s, input int m, input int h,
                        input int tick, input int wrap, input int err, input int alm);
        ev_t e;
        e.c = c; e.s = s; e.m = m; e.h = h;
        e.tick = tick; e.wrap = wrap; e.err = err; e.alm = alm;
        q.push_back(e);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: any strobe must match the queue head at exactly the expected cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].c < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_event: actual none by cycle %0d, required strobe at cycle %0d",
                     cyc, q[0].c);
            void'(q.pop_front());
        end
        if (sec_tick || day_wrap || load_err) begin
            if (q.size() == 0 || q[0].c != cyc) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe at cycle %0d: actual tick=%0d wrap=%0d err=%0d, required none",
                         cyc, sec_tick, day_wrap, load_err);
            end else begin
                mon_e = q.pop_front();
                check("ev_sec", int'(sec_cnt), mon_e.s);
                check("ev_min", int'(min_cnt), mon_e.m);
                check("ev_hour", int'(hour_cnt), mon_e.h);
                check("ev_sec_tick", int'(sec_tick), mon_e.tick);
                check("ev_day_wrap", int'(day_wrap), mon_e.wrap);
                check("ev_load_err", int'(load_err), mon_e.err);
`ifdef CLOCK_RTC_ALARM_EN
                check("ev_alarm", int'(alarm), mon_e.alm);
`endif
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: actual timeout at cycle %0d, required finish", cyc);
        $fatal(1);
    end

    int r, l, e, f, r2, last;

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        wait_until(3);
        check("rst_sec", int'(sec_cnt), 0);
        check("rst_min", int'(min_cnt), 0);
        check("rst_hour", int'(hour_cnt), 0);
        check("rst_strobes", int'({sec_tick, day_wrap, load_err}), 0);
        r   = cyc;
        rst = 1'b0;
        push(r + 4, 1, 0, 0, 1, 0, 0, 0);
        push(r + 8, 2, 0, 0, 1, 0, 0, 0);
        push(r + 12, 3, 0, 0, 1, 0, 0, 0);
        wait_until(r + 3);
        check("pre_first_tick_sec", int'(sec_cnt), 0);

        // Valid load 23:59:58 mid-second, then run through the day rollover.
        wait_until(r + 13);
        load_sec = 6'd58; load_min = 6'd59; load_hour = 5'd23; load = 1'b1;
        l = cyc + 1;
        push(l + 4, 59, 59, 23, 1, 0, 0, 0);
        push(l + 8, 0, 0, 0, 1, 1, 0, 0);
        @(negedge clk);
        load = 1'b0;
        check("load_sec", int'(sec_cnt), 58);
        check("load_min", int'(min_cnt), 59);
        check("load_hour", int'(hour_cnt), 23);

        // Freeze the prescaler for 10 cycles; the tick slips by exactly 10.
        wait_until(l + 9);
        en = 1'b0;
        wait_until(l + 19);
        en = 1'b1;
        e = l + 22;
        push(e, 1, 0, 0, 1, 0, 0, 0);

        // Invalid load on an advance edge, then another one mid-second.
        wait_until(e + 3);
        load_sec = 6'd60; load_min = 6'd0; load_hour = 5'd0; load = 1'b1;
        push(e + 4, 2, 0, 0, 1, 0, 1, 0);
        @(negedge clk);
        load = 1'b0;
        wait_until(e + 5);
        load_sec = 6'd0; load_min = 6'd60; load = 1'b1;
        push(e + 6, 2, 0, 0, 0, 0, 1, 0);
        push(e + 8, 3, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        load = 1'b0;

        // Valid load coincident with an advance, then reset mid-second.
        f = e + 8;
        wait_until(f + 3);
        load_sec = 6'd56; load_min = 6'd34; load_hour = 5'd12; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("adv_load_sec", int'(sec_cnt), 56);
        check("adv_load_min", int'(min_cnt), 34);
        check("adv_load_hour", int'(hour_cnt), 12);
        wait_until(f + 5);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_sec", int'(sec_cnt), 0);
        check("midrst_min", int'(min_cnt), 0);
        check("midrst_hour", int'(hour_cnt), 0);
        rst = 1'b0;
        r2 = cyc;
        push(r2 + 4, 1, 0, 0, 1, 0, 0, 0);

        // Loads with en low: valid is taken, invalid hour is rejected.
        wait_until(r2 + 5);
        en = 1'b0;
        load_sec = 6'd7; load_min = 6'd6; load_hour = 5'd5; load = 1'b1;
        @(negedge clk);
        check("en0_load_sec", int'(sec_cnt), 7);
        check("en0_load_min", int'(min_cnt), 6);
        check("en0_load_hour", int'(hour_cnt), 5);
        load_hour = 5'd24;
        push(r2 + 7, 7, 6, 5, 0, 0, 1, 0);
        @(negedge clk);
        load = 1'b0;
        wait_until(r2 + 12);
        check("en0_frozen_sec", int'(sec_cnt), 7);
        last = cyc;

`ifdef CLOCK_RTC_ALARM_EN
        // Alarm at 0:1, start from 0:0:58; rises on 0:1:0 and holds until acked.
        alarm_hour = 5'd0; alarm_min = 6'd1; alarm_wr = 1'b1;
        load_sec = 6'd58; load_min = 6'd0; load_hour = 5'd0; load = 1'b1;
        l = cyc;
        @(negedge clk);
        alarm_wr = 1'b0;
        load = 1'b0;
        en = 1'b1;
        check("alarm_after_load", int'(alarm), 0);
        push(l + 5, 59, 0, 0, 1, 0, 0, 0);
        push(l + 9, 0, 1, 0, 1, 0, 0, 1);
        wait_until(l + 11);
        check("alarm_held", int'(alarm), 1);
        alarm_ack = 1'b1;
        @(negedge clk);
        alarm_ack = 1'b0;
        check("alarm_acked", int'(alarm), 0);
        push(l + 13, 1, 1, 0, 1, 0, 0, 0);
        last = l + 13;
`endif

        wait_until(last + 2);
        while (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL pending_event: actual none, required strobe at cycle %0d", q[0].c);
            void'(q.pop_front());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_rtc_param.md
Name: clock_rtc_param

Overview:
- Parametrised time-of-day counter with an integrated prescaler.
- Successor to the fixed 60/60/24 counter. Programmable limits, synchronous time load with range check, and second/day-rollover strobes.
- Sits between the system clock domain and display/alarm logic. Single clock, no CDC.

Parameters:
- TICKS_PER_SEC, 100000000, clk cycles per second; must be >= 2.
- SEC_MAX, 60, seconds per minute (count range 0..SEC_MAX-1).
- MIN_MAX, 60, minutes per hour.
- HOUR_MAX, 24, hours per day.
- Derived, not overridable: SW=$clog2(SEC_MAX), MW=$clog2(MIN_MAX), HW=$clog2(HOUR_MAX), PW=$clog2(TICKS_PER_SEC).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  count enable; prescaler frozen when low.
- load  in  1  one-cycle request to load time from the load_* fields.
- load_sec  in  SW  seconds value to load.
- load_min  in  MW  minutes value to load.
- load_hour  in  HW  hours value to load.
- sec_cnt  out  SW  current seconds, registered.
- min_cnt  out  MW  current minutes, registered.
- hour_cnt  out  HW  current hours, registered.
- sec_tick  out  1  one-cycle pulse, high in the cycle the new sec_cnt is visible.
- day_wrap  out  1  one-cycle pulse, high in the cycle hour:min:sec first reads 0:0:0 after rollover.
- load_err  out  1  one-cycle pulse, high the cycle after a rejected load.

Behaviour:
- Reset: pre_cnt, sec_cnt, min_cnt, hour_cnt = 0. sec_tick, day_wrap, load_err = 0. Reset overrides load and en.
- Prescaler pre_cnt (PW bits):
  - en=1: increments each cycle.
  - At TICKS_PER_SEC-1 it wraps to 0 and raises internal adv on that edge.
  - en=0: holds value; no adv.
- Advance (adv=1, no load):
  - sec<SEC_MAX-1: sec+1.
  - Otherwise sec=0. Then min<MIN_MAX-1: min+1.
  - Otherwise min=0. Then hour<HOUR_MAX-1: hour+1, else hour=0.
- Output strobes:
  - sec_tick registered, asserted the cycle after the adv edge, coincident with the updated counts.
  - day_wrap asserted in the same cycle as sec_tick when all three fields wrapped.
  - First sec_tick after reset with en held high lands TICKS_PER_SEC cycles after rst deasserts.
- Load (priority over adv):
  - Valid load requires load_sec<SEC_MAX, load_min<MIN_MAX, load_hour<HOUR_MAX.
  - Valid: all three fields take load values. pre_cnt=0. No sec_tick/day_wrap that cycle, even if adv coincided.
  - Invalid: counters and pre_cnt unchanged, the coinciding adv is still honoured, load_err pulses next cycle.
  - Load is accepted whether en is 0 or 1.
- Counts are never out of range. No state outside 0..MAX-1 is reachable except through reset.
- Mid-operation rst clears the prescaler phase; the next second is a full TICKS_PER_SEC later.

Optional Feature:
- Macro: CLOCK_RTC_ALARM_EN.
- Defined, adds ports:
  - alarm_wr in 1
  - alarm_hour in HW
  - alarm_min in MW
  - alarm_ack in 1
  - alarm out 1
- alarm_wr latches alarm_hour/alarm_min into alarm registers (reset 0, disarmed) and arms the alarm.
- When armed and an adv produces sec=0 with min/hour equal to the registers, alarm goes high with sec_tick and stays high (level) until alarm_ack.
- alarm_ack clears alarm next cycle. If ack coincides with a new match, the match wins.
- Load never triggers alarm.
- Undefined: ports absent, no alarm logic; behaviour otherwise identical.

Test Plan:
- TICKS_PER_SEC=4, en=1 from reset -> sec_tick every 4 cycles, first at cycle 4; sec_cnt steps 0,1,2.
- load 23:59:58 valid, run 2 seconds -> 23:59:59, then 0:0:0 with day_wrap=1 for exactly 1 cycle alongside sec_tick.
- en toggled low for 10 cycles mid-second -> pre_cnt frozen, sec_tick delayed exactly 10 cycles.
- load_sec=60 (invalid) issued on an adv cycle -> counts advance normally, load_err=1 next cycle, pre_cnt not cleared.
- Valid load coincident with adv, then rst asserted mid-second -> loaded value taken, no sec_tick; rst clears all outputs and the first tick comes 4 cycles after release.
- CLOCK_RTC_ALARM_EN, alarm_wr 0:1, start 0:0:58 -> alarm rises when 0:1:0 appears and holds until alarm_ack, low the next cycle.
